alu_operand_seq: RTL and testbench
==================================

ALU_OPERAND_SEQ -- requirements
Module: alu_operand_seq

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 500000, the number of consecutive stable clk cycles required to accept a key level change (10 ms at 50 MHz).
REQ-002 SHALL have port clk  input  1  single system clock; all logic on the rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port sw  input  4  raw data switches, asynchronous to clk.
REQ-005 SHALL have port key  input  1  raw push button, active-low (0 = pressed), bouncing, asynchronous to clk.
REQ-006 SHALL have port clr  input  1  synchronous abort back to operand-A entry, active-high.
REQ-007 SHALL have port A  output  4  registered operand A to the ALU.
REQ-008 SHALL have port B  output  4  registered operand B to the ALU.
REQ-009 SHALL have port ALUstr  output  3  registered ALU opcode (0 add … 7 equal).
REQ-010 SHALL have port valid  output  1  high while A/B/ALUstr form a complete, committed operation.
REQ-011 SHALL have port state  output  2  current FSM state code, for status LEDs.

Function
REQ-012 SHALL pass key and sw through two-flop synchronizers before any use.
REQ-013 SHALL keep a debounced key level that changes only after the synchronized key differs from it for DEB_CYCLES consecutive cycles; any cycle matching the current level clears the stability counter.
REQ-014 SHALL generate a one-cycle press pulse on the debounced 1->0 transition; release (0->1) generates nothing.
REQ-015 SHALL implement FSM S_A=0, S_B=1, S_OP=2, S_RUN=3; state output equals the code.
REQ-016 On a press in S_A SHALL load A <= synchronized sw and go to S_B.
REQ-017 On a press in S_B SHALL load B <= synchronized sw and go to S_OP.
REQ-018 On a press in S_OP SHALL load ALUstr <= synchronized sw[2:0] (sw[3] ignored) and go to S_RUN.
REQ-019 On a press in S_RUN SHALL go to S_A; A, B and ALUstr are retained until overwritten.
REQ-020 SHALL drive valid = 1 exactly when state == S_RUN; valid rises on the edge that loads ALUstr.
REQ-021 Latency: the register load and state change SHALL occur on the clk edge that ends the press-pulse cycle.
REQ-022 clr = 1 SHALL force state to S_A and valid to 0 on the next edge, leaving A/B/ALUstr unchanged; clr takes priority over a simultaneous press.
REQ-023 A held key SHALL produce exactly one press; bounces shorter than DEB_CYCLES SHALL produce none.
REQ-024 The stability counter SHALL saturate, never wrap, and SHALL be sized ceil(log2(DEB_CYCLES+1)) bits.

Reset
REQ-025 While rst_n = 0 SHALL asynchronously set state = S_A, A = 0, B = 0, ALUstr = 0, valid = 0.
REQ-026 Reset SHALL set the synchronizer flops and the debounced level to 1 (released) and the counter to 0, so that deassertion produces no spurious press.
REQ-027 Reset asserted mid-debounce or in any state SHALL discard the partial operation.

Configuration
REQ-028 With macro ALU_SEQ_DEBOUNCE_EN defined, SHALL include the debouncer per REQ-013/024.
REQ-029 Without ALU_SEQ_DEBOUNCE_EN, SHALL omit the counter: the debounced level equals the synchronized key, and the press pulse is its 1->0 edge; DEB_CYCLES is ignored.

Verification (DEB_CYCLES = 4, macro defined unless stated)
REQ-030 SHALL check: reset released, key=1 for 20 cycles -> state=0, A=B=ALUstr=0, valid=0, no press.
REQ-031 SHALL check: sw=5 press, sw=3 press, sw=0 press (each held 10 cycles) -> A=5, B=3, ALUstr=0, state=3, valid=1.
REQ-032 SHALL check: key toggles every 2 cycles for 20 cycles, then returns to 1 -> no state change.
REQ-033 SHALL check: in S_RUN, press with clr=1 in the same pulse cycle -> state=0, valid=0, A/B/ALUstr held.
REQ-034 SHALL check: sw=4'b1110 press in S_OP -> ALUstr=3'b110.
REQ-035 SHALL check: macro undefined, single clean 1-cycle-synchronized press -> state advances 3 cycles after the key falls (2 sync + 1 edge).

Source files
------------

// File: rtl/alu_operand_seq.sv
// Debounced push-button sequencer that collects ALU operand A, operand B and opcode from switches.
// Optional debouncer enabled by defining ALU_SEQ_DEBOUNCE_EN; otherwise the synchronized key is used directly.
module alu_operand_seq #(
  parameter int unsigned DEB_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw,
  input  logic       key,
  input  logic       clr,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic [2:0] ALUstr,
  output logic       valid,
  output logic [1:0] state
);

  localparam int unsigned DW = 4;
  localparam int unsigned OW = 3;

  typedef enum logic [1:0] {
    S_A   = 2'd0,
    S_B   = 2'd1,
    S_OP  = 2'd2,
    S_RUN = 2'd3
  } state_t;

  if (DEB_CYCLES == 0) begin : g_bad_deb
    $error("DEB_CYCLES must be at least 1");
  end

  state_t          st_q;
  state_t          st_d;
  logic [DW-1:0]   a_d;
  logic [DW-1:0]   b_d;
  logic [OW-1:0]   op_d;
  logic            valid_d;

  logic            key_meta;
  logic            key_sync;
  logic [DW-1:0]   sw_meta;
  logic [DW-1:0]   sw_sync;
  logic            deb_level;
  logic            deb_prev;
  logic            press_c;

  // Two-flop synchronizers; reset to "released" so deassertion cannot look like a press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_meta <= 1'b1;
      key_sync <= 1'b1;
      sw_meta  <= '1;
      sw_sync  <= '1;
    end else begin
      key_meta <= key;
      key_sync <= key_meta;
      sw_meta  <= sw;
      sw_sync  <= sw_meta;
    end
  end

`ifdef ALU_SEQ_DEBOUNCE_EN
  localparam int unsigned     CNT_W    = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [CNT_W-1:0] deb_cnt;

  // Level flips on the DEB_CYCLES-th consecutive differing cycle; counter never passes CNT_LAST
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_level <= 1'b1;
      deb_cnt   <= '0;
    end else if (key_sync == deb_level) begin
      deb_cnt   <= '0;
    end else if (deb_cnt >= CNT_LAST) begin
      deb_level <= key_sync;
      deb_cnt   <= '0;
    end else begin
      deb_cnt   <= deb_cnt + CNT_W'(1);
    end
  end
`else
  assign deb_level = key_sync;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_prev <= 1'b1;
    end else begin
      deb_prev <= deb_level;
    end
  end

  // Key is active-low: a press is the debounced 1->0 edge only
  assign press_c = deb_prev & ~deb_level;

  always_comb begin
    st_d    = st_q;
    a_d     = A;
    b_d     = B;
    op_d    = ALUstr;
    valid_d = 1'b0;
    if (clr) begin
      st_d = S_A;
    end else if (press_c) begin
      case (st_q)
        S_A: begin
          a_d  = sw_sync;
          st_d = S_B;
        end
        S_B: begin
          b_d  = sw_sync;
          st_d = S_OP;
        end
        S_OP: begin
          op_d = sw_sync[OW-1:0];
          st_d = S_RUN;
        end
        default: begin
          st_d = S_A;
        end
      endcase
    end
    valid_d = (st_d == S_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= S_A;
      A      <= '0;
      B      <= '0;
      ALUstr <= '0;
      valid  <= 1'b0;
    end else begin
      st_q   <= st_d;
      A      <= a_d;
      B      <= b_d;
      ALUstr <= op_d;
      valid  <= valid_d;
    end
  end

  assign state = st_q;

endmodule

// File: tb/tb_alu_operand_seq.sv
// Scoreboard bench for alu_operand_seq: stimulus queues expected output snapshots, a monitor
// compares each observed output change against the queue head.
module tb_alu_operand_seq;

  localparam int unsigned DEB = 4;
`ifdef ALU_SEQ_DEBOUNCE_EN
  localparam int LAT = 7;
  localparam int MID = 4;
`else
  localparam int LAT = 3;
  localparam int MID = 2;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] sw = 4'd0;
  logic       key = 1'b1;
  logic       clr = 1'b0;
  logic [3:0] A;
  logic [3:0] B;
  logic [2:0] ALUstr;
  logic       valid;
  logic [1:0] state;

  int total = 0;
  int bad = 0;
  logic [13:0] exp_q[$];
  logic [13:0] last_snap = 14'd0;
  logic [13:0] exp_v;
  logic [13:0] snap;

  alu_operand_seq #(.DEB_CYCLES(DEB)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sw     (sw),
    .key    (key),
    .clr    (clr),
    .A      (A),
    .B      (B),
    .ALUstr (ALUstr),
    .valid  (valid),
    .state  (state)
  );

  always #5 clk = ~clk;

  assign snap = {state, A, B, ALUstr, valid};

  function automatic logic [13:0] pack(input logic [1:0] s, input logic [3:0] a,
                                       input logic [3:0] b, input logic [2:0] o,
                                       input logic v);
    return {s, a, b, o, v};
  endfunction

  // Monitor: every change of the output bundle must match the next queued expectation
  always @(negedge clk) begin
    if (snap !== last_snap) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_change got=%h (state=%0d A=%0d B=%0d op=%0d v=%0b)",
                 snap, state, A, B, ALUstr, valid);
      end else begin
        exp_v = exp_q.pop_front();
        if (snap !== exp_v) begin
          bad++;
          $display("FAIL transition got=%h want=%h", snap, exp_v);
        end
      end
      last_snap = snap;
    end
  end

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic do_press(input logic [3:0] v, input logic with_clr);
    @(negedge clk);
    sw = v;
    repeat (3) @(negedge clk);
    key = 1'b0;
    clr = with_clr;
    repeat (10) @(negedge clk);
    clr = 1'b0;
    key = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("reset_state", int'(state), 0);
    check("reset_A", int'(A), 0);
    check("reset_B", int'(B), 0);
    check("reset_op", int'(ALUstr), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_no_press", exp_q.size(), 0);

    // First press also measures key-fall-to-state latency
    exp_q.push_back(pack(2'd1, 4'd5, 4'd0, 3'd0, 1'b0));
    @(negedge clk);
    sw = 4'd5;
    repeat (3) @(negedge clk);
    key = 1'b0;
    n = 0;
    while (state == 2'd0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("press_latency", n, LAT);
    repeat (10) @(negedge clk);
    key = 1'b1;
    repeat (10) @(negedge clk);

    exp_q.push_back(pack(2'd2, 4'd5, 4'd3, 3'd0, 1'b0));
    do_press(4'd3, 1'b0);
    exp_q.push_back(pack(2'd3, 4'd5, 4'd3, 3'd0, 1'b1));
    do_press(4'd0, 1'b0);
    check("seq1_state", int'(state), 3);
    check("seq1_A", int'(A), 5);
    check("seq1_B", int'(B), 3);
    check("seq1_op", int'(ALUstr), 0);
    check("seq1_valid", int'(valid), 1);
    check("seq1_drained", exp_q.size(), 0);

`ifdef ALU_SEQ_DEBOUNCE_EN
    // Bounce of 2-cycle pulses is shorter than DEB_CYCLES: no press expected
    for (int i = 0; i < 10; i++) begin
      key = ~key;
      repeat (2) @(negedge clk);
    end
    key = 1'b1;
    repeat (20) @(negedge clk);
    check("bounce_state", int'(state), 3);
    check("bounce_drained", exp_q.size(), 0);
`endif

    // clr with a press in S_RUN: back to S_A, operands held
    exp_q.push_back(pack(2'd0, 4'd5, 4'd3, 3'd0, 1'b0));
    do_press(4'd7, 1'b1);
    check("clr_run_drained", exp_q.size(), 0);

    // clr beats a press in S_A: nothing may change
    do_press(4'd9, 1'b1);
    check("clr_prio_drained", exp_q.size(), 0);
    check("clr_prio_A", int'(A), 5);

    exp_q.push_back(pack(2'd1, 4'd2, 4'd3, 3'd0, 1'b0));
    do_press(4'd2, 1'b0);
    exp_q.push_back(pack(2'd2, 4'd2, 4'd12, 3'd0, 1'b0));
    do_press(4'd12, 1'b0);
    exp_q.push_back(pack(2'd3, 4'd2, 4'd12, 3'd6, 1'b1));
    do_press(4'b1110, 1'b0);
    check("op_sw3_ignored", int'(ALUstr), 6);
    exp_q.push_back(pack(2'd0, 4'd2, 4'd12, 3'd6, 1'b0));
    do_press(4'd1, 1'b0);
    exp_q.push_back(pack(2'd1, 4'd8, 4'd12, 3'd6, 1'b0));
    do_press(4'd8, 1'b0);
    check("seq2_drained", exp_q.size(), 0);

    // Reset with a press in flight discards everything
    exp_q.push_back(pack(2'd0, 4'd0, 4'd0, 3'd0, 1'b0));
    @(negedge clk);
    key = 1'b0;
    repeat (MID) @(negedge clk);
    rst_n = 1'b0;
    key = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("midreset_state", int'(state), 0);
    check("midreset_A", int'(A), 0);
    check("midreset_valid", int'(valid), 0);
    check("midreset_drained", exp_q.size(), 0);

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
